// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Turns the UART receiver byte stream into framed commands:
//   SYNC, CMD, LEN, PAYLOAD[LEN], CHK   with CHK = CMD ^ LEN ^ payload bytes.
// A checksum-good frame is held (valid, cmd, len, payload) until the decoder
// acknowledges it. Checksum, length and inter-byte timeout errors pulse o_err
// with a sticky o_err_code; bytes arriving while a frame is held pulse o_overrun.
// Optional frame/error statistics counters are compiled in when the macro
// UART_FRAME_STATS_EN is defined.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 15,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rcv,
  input  logic [7:0]  i_data,
  input  logic        i_frame_ack,
  input  logic [3:0]  i_rd_addr,
  output logic [7:0]  o_rd_data,
  output logic        o_frame_valid,
  output logic [7:0]  o_cmd,
  output logic [3:0]  o_len,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_overrun
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
`endif
);

  localparam int            TW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_reg;
  logic [7:0]    cmd_reg;
  logic [7:0]    chk_reg;
  logic [3:0]    len_reg;
  logic [3:0]    idx_reg;
  logic [TW-1:0] tmo_reg;
  logic          valid_reg;
  logic          err_reg;
  logic [1:0]    err_code_reg;
  logic          overrun_reg;
  logic [7:0]    payload_reg [16];
  logic [7:0]    rd_view     [16];

  logic in_frame;
  logic tmo_hit;
  logic len_bad;
  logic chk_good;
  logic chk_bad;
  logic ovr_hit;
  logic sync_seen;

  // Decode this cycle's events; a received byte always pre-empts the timeout.
  always_comb begin
    in_frame  = (state_reg == S_CMD) || (state_reg == S_LEN) ||
                (state_reg == S_PAYLOAD) || (state_reg == S_CHK);
    sync_seen = i_rcv && (i_data == SYNC_BYTE);
    tmo_hit   = in_frame && !i_rcv && (tmo_reg == TMO_LAST);
    len_bad   = (state_reg == S_LEN) && i_rcv && (i_data > MAX_LEN_B);
    chk_good  = (state_reg == S_CHK) && i_rcv && (i_data == chk_reg);
    chk_bad   = (state_reg == S_CHK) && i_rcv && (i_data != chk_reg);
    ovr_hit   = (state_reg == S_DONE) && i_rcv && !i_frame_ack;
  end

  // Frame sequencer: state, checksum, payload buffer, timeout and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cmd_reg      <= '0;
      chk_reg      <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
      tmo_reg      <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
      overrun_reg  <= 1'b0;
      for (int i = 0; i < 16; i++) payload_reg[i] <= '0;
    end else begin
      err_reg     <= len_bad || chk_bad || tmo_hit;
      overrun_reg <= ovr_hit;

      // Idle-gap counter only runs while a frame is being assembled.
      if (!in_frame || i_rcv || tmo_hit) tmo_reg <= '0;
      else                               tmo_reg <= tmo_reg + TW'(1);

      if (tmo_hit) begin
        err_code_reg <= 2'b11;
        state_reg    <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (sync_seen) state_reg <= S_CMD;
          end
          S_CMD: begin
            if (i_rcv) begin
              cmd_reg   <= i_data;
              chk_reg   <= i_data;
              state_reg <= S_LEN;
            end
          end
          S_LEN: begin
            if (len_bad) begin
              err_code_reg <= 2'b10;
              state_reg    <= S_IDLE;
            end else if (i_rcv) begin
              len_reg   <= i_data[3:0];
              chk_reg   <= chk_reg ^ i_data;
              idx_reg   <= '0;
              state_reg <= (i_data == 8'h00) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (i_rcv) begin
              payload_reg[idx_reg] <= i_data;
              chk_reg              <= chk_reg ^ i_data;
              // idx stops at the last slot rather than running one past it.
              if (idx_reg == len_reg - 4'd1) state_reg <= S_CHK;
              else                           idx_reg   <= idx_reg + 4'd1;
            end
          end
          S_CHK: begin
            if (chk_good) begin
              valid_reg <= 1'b1;
              state_reg <= S_DONE;
            end else if (chk_bad) begin
              err_code_reg <= 2'b01;
              state_reg    <= S_IDLE;
            end
          end
          S_DONE: begin
            // The ack releases the frame; a byte in the same cycle is treated
            // as the first byte seen in IDLE.
            if (i_frame_ack) begin
              valid_reg <= 1'b0;
              state_reg <= sync_seen ? S_CMD : S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // Masked read view: entries at or beyond the held length read as zero.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rd_view
    assign rd_view[gi] = (4'(gi) < len_reg) ? payload_reg[gi] : 8'h00;
  end

  assign o_rd_data     = rd_view[i_rd_addr];
  assign o_frame_valid = valid_reg;
  assign o_cmd         = cmd_reg;
  assign o_len         = len_reg;
  assign o_err         = err_reg;
  assign o_err_code    = err_code_reg;
  assign o_overrun     = overrun_reg;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] frame_cnt_reg;
  logic [15:0] err_cnt_reg;

  // Wrapping statistics: completed frames, and error plus overrun events.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (chk_good) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (len_bad || chk_bad || tmo_hit || ovr_hit) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_reg;
  assign o_err_cnt   = err_cnt_reg;
`endif

endmodule
